instr_encoder: RTL

Packs field-level instruction descriptors (format, opcode, funct3/funct7, register indices, 64-bit immediate) into raw 32-bit RV64 instruction words, the inverse of the front-end decoder. It also expands the `LI` pseudo-op into one or two real instructions. It sits between the self-test program generator and the instruction-memory write port, with valid/ready handshakes on both sides. It provides one output register stage and a two-state expansion FSM.

---
 rtl/instr_encoder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: packs instruction descriptors into raw RV64 instruction words.
// Expands the LI pseudo-op into ADDI, or into LUI plus an optional ADDIW.
// Provides a single output register stage with a valid/ready handshake on each side.
module instr_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_f3,
    input  logic [6:0]  in_f7,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [63:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err
);

    localparam logic [2:0] FMT_R  = 3'd0;
    localparam logic [2:0] FMT_I  = 3'd1;
    localparam logic [2:0] FMT_S  = 3'd2;
    localparam logic [2:0] FMT_B  = 3'd3;
    localparam logic [2:0] FMT_U  = 3'd4;
    localparam logic [2:0] FMT_J  = 3'd5;
    localparam logic [2:0] FMT_LI = 3'd6;

    localparam logic [6:0] OP_ADDI  = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_ADDIW = 7'b0011011;

    typedef enum logic {
        IDLE = 1'b0,
        LI2  = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pend_instr;

    logic        accept;
    logic        out_fire;

    logic        fit12;
    logic        fit13;
    logic        fit21;
    logic        fit32;
    logic [19:0] li_hi;
    logic [11:0] li_lo;

    logic [31:0] enc_word;
    logic        enc_err;
    logic        enc_two;
    logic [31:0] enc_second;

    // Signed-range checks: the upper bits must all equal the sign bit
    assign fit12 = (in_imm[63:11] == {53{in_imm[63]}});
    assign fit13 = (in_imm[63:12] == {52{in_imm[63]}});
    assign fit21 = (in_imm[63:20] == {44{in_imm[63]}});
    assign fit32 = (in_imm[63:31] == {33{in_imm[63]}});

    // LI split: rounding hi by bit 11 compensates for the sign-extended lo
    assign li_hi = in_imm[31:12] + 20'(in_imm[11]);
    assign li_lo = in_imm[11:0];

    // Handshake: a pending ADDIW blocks new descriptors
    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Field packing and legality check for the presented descriptor
    always_comb begin
        enc_word   = '0;
        enc_err    = 1'b0;
        enc_two    = 1'b0;
        enc_second = '0;
        case (in_fmt)
            FMT_R: begin
                enc_word = {in_f7, in_rs2, in_rs1, in_f3, in_rd, in_opcode};
            end
            FMT_I: begin
                enc_err  = !fit12;
                enc_word = {in_imm[11:0], in_rs1, in_f3, in_rd, in_opcode};
            end
            FMT_S: begin
                enc_err  = !fit12;
                enc_word = {in_imm[11:5], in_rs2, in_rs1, in_f3, in_imm[4:0], in_opcode};
            end
            FMT_B: begin
                enc_err  = !fit13 || in_imm[0];
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_f3,
                            in_imm[4:1], in_imm[11], in_opcode};
            end
            FMT_U: begin
                enc_err  = !fit32 || (in_imm[11:0] != 12'd0);
                enc_word = {in_imm[31:12], in_rd, in_opcode};
            end
            FMT_J: begin
                enc_err  = !fit21 || in_imm[0];
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                            in_rd, in_opcode};
            end
            FMT_LI: begin
                enc_err = !fit32;
                if (fit12) begin
                    enc_word = {li_lo, 5'd0, 3'd0, in_rd, OP_ADDI};
                end else begin
                    enc_word   = {li_hi, in_rd, OP_LUI};
                    enc_two    = (li_lo != 12'd0);
                    enc_second = {li_lo, in_rd, 3'd0, in_rd, OP_ADDIW};
                end
            end
            default: begin
                enc_err = 1'b1;
            end
        endcase
        if (enc_err) begin
            enc_word = '0;
            enc_two  = 1'b0;
        end
    end

    // Expansion FSM and output register stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            out_instr  <= '0;
            out_err    <= 1'b0;
            pend_instr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        out_valid  <= 1'b1;
                        out_instr  <= enc_word;
                        out_err    <= enc_err;
                        pend_instr <= enc_second;
                        if (enc_two) begin
                            state <= LI2;
                        end
                    end else if (out_fire) begin
                        out_valid <= 1'b0;
                    end
                end
                LI2: begin
                    if (out_fire) begin
                        out_instr <= pend_instr;
                        out_err   <= 1'b0;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
